spi_frame_rx: RTL

SPI_FRAME_RX -- requirements
Module: spi_frame_rx

---
 rtl/spi_frame_rx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/spi_frame_rx.sv
// SPI mode-0 16-bit frame receiver with one-entry output buffer and error pulses.
// Optional saturating error counter output enabled by SPI_FRAME_RX_ERRCNT_EN.
module spi_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       frame_rw,
  output logic [6:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       err_short,
  output logic       err_long,
  output logic       err_ovf
`ifdef SPI_FRAME_RX_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, WAIT_HI} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_h, copi_h, ncs_h;
  logic                   sclk_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;
  logic                   eval, load;

  state_t      state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_h    <= 1'b0;
      copi_h    <= 1'b0;
      ncs_h     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_h    <= sclk_sync[SYNC_STAGES-1];
      copi_h    <= copi_sync[SYNC_STAGES-1];
      ncs_h     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    ncs_s     = ncs_sync[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_h;
    ncs_rise  = ncs_s & ~ncs_h;
    ncs_fall  = ~ncs_s & ncs_h;
    eval      = (state == SHIFT) && ncs_rise;
    load      = eval && (bit_cnt == 5'd16);
  end

  // Data is taken from the copi history flop: it is the value seen one clk
  // before the detected sclk rise, well inside the stable window of mode 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_rw    <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_ovf   <= 1'b0;

      case (state)
        IDLE:    state <= ncs_s ? ARMED : WAIT_HI;
        WAIT_HI: if (ncs_s) state <= ARMED;
        ARMED: begin
          if (ncs_fall) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= ARMED;
            if (bit_cnt == 5'd17)
              err_long <= 1'b1;
            else if (bit_cnt != 5'd0 && bit_cnt != 5'd16)
              err_short <= 1'b1;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_h};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        if (frame_valid && !frame_ready) begin
          err_ovf <= 1'b1;
        end else begin
          frame_valid <= 1'b1;
          frame_rw    <= shift_reg[15];
          frame_addr  <= shift_reg[14:8];
          frame_data  <= shift_reg[7:0];
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_RX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= '0;
    else if ((err_short || err_long || err_ovf) && err_count != 8'd255)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule
